// File: rtl/sap1_out_pkg.sv
// Shared types and glyph constants for the SAP-1 output register / display block.
package sap1_out_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADJUST,
        SHIFT,
        COMMIT
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for decimal digits 0-9
    localparam logic [7:0] DIGIT_GLYPH [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

endpackage

// File: rtl/sap1_out_display_sevenseg_decode.sv
// BCD nibble to active-low 7-segment pattern; blank flag or non-decimal nibble gives all-off.
module sevenseg_decode
    import sap1_out_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && nibble <= 4'd9) begin
            seg = DIGIT_GLYPH[nibble];
        end
    end

endmodule

// File: rtl/sap1_out_display.sv
// SAP-1 output register: captures DBUS on nLO at the CLK rising edge, converts to BCD
// with a sequential double-dabble engine and scans a 4-digit active-low display.
module sap1_out_display
    import sap1_out_pkg::*;
#(
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic       CLK,
    input  logic       nLO,
    input  logic [7:0] DBUS,
    input  logic       signed_mode,
    output logic [7:0] out_value,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    state_e           state_q, state_d;
    logic             clk_prev_q;
    logic [7:0]       out_value_q, out_value_d;
    logic [19:0]      sh_q, sh_d;
    logic [2:0]       iter_q, iter_d;
    logic             neg_work_q, neg_work_d;
    logic [11:0]      bcd_disp_q, bcd_disp_d;
    logic             neg_disp_q, neg_disp_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q, idx_d;

    logic             load_evt;
    logic             neg_in;
    logic [7:0]       mag;

    assign load_evt = CLK & ~clk_prev_q & ~nLO;
    assign neg_in   = signed_mode & DBUS[7];
    assign mag      = neg_in ? (~DBUS + 8'd1) : DBUS;

    // A load in any state restarts the conversion; a partial result is never committed
    always_comb begin
        state_d     = state_q;
        out_value_d = out_value_q;
        sh_d        = sh_q;
        iter_d      = iter_q;
        neg_work_d  = neg_work_q;
        bcd_disp_d  = bcd_disp_q;
        neg_disp_d  = neg_disp_q;
        if (load_evt) begin
            out_value_d = DBUS;
            sh_d        = {12'd0, mag};
            iter_d      = 3'd0;
            neg_work_d  = neg_in;
            state_d     = ADJUST;
        end else begin
            case (state_q)
                ADJUST: begin
                    for (int i = 0; i < 3; i++) begin
                        if (sh_q[8 + 4*i +: 4] >= 4'd5) begin
                            sh_d[8 + 4*i +: 4] = sh_q[8 + 4*i +: 4] + 4'd3;
                        end
                    end
                    state_d = SHIFT;
                end
                SHIFT: begin
                    sh_d    = {sh_q[18:0], 1'b0};
                    iter_d  = iter_q + 3'd1;
                    state_d = (iter_q == 3'd7) ? COMMIT : ADJUST;
                end
                COMMIT: begin
                    bcd_disp_d = sh_q[19:8];
                    neg_disp_d = neg_work_q;
                    state_d    = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q     <= IDLE;
            clk_prev_q  <= 1'b0;
            out_value_q <= 8'd0;
            sh_q        <= 20'd0;
            iter_q      <= 3'd0;
            neg_work_q  <= 1'b0;
            bcd_disp_q  <= 12'd0;
            neg_disp_q  <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            clk_prev_q  <= CLK;
            out_value_q <= out_value_d;
            sh_q        <= sh_d;
            iter_q      <= iter_d;
            neg_work_q  <= neg_work_d;
            bcd_disp_q  <= bcd_disp_d;
            neg_disp_q  <= neg_disp_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
        end
    end

    // Leading-zero blanking: tens only blank when hundreds is also zero
    logic [3:0] dig_nib;
    logic       dig_blank;
    logic [7:0] dec_seg;

    always_comb begin
        dig_nib   = 4'd0;
        dig_blank = 1'b1;
        case (idx_q)
            2'd0: begin
                dig_nib   = bcd_disp_q[3:0];
                dig_blank = 1'b0;
            end
            2'd1: begin
                dig_nib   = bcd_disp_q[7:4];
                dig_blank = (bcd_disp_q[11:8] == 4'd0) && (bcd_disp_q[7:4] == 4'd0);
            end
            2'd2: begin
                dig_nib   = bcd_disp_q[11:8];
                dig_blank = (bcd_disp_q[11:8] == 4'd0);
            end
            default: ;
        endcase
    end

    sevenseg_decode u_dec (
        .nibble (dig_nib),
        .blank  (dig_blank),
        .seg    (dec_seg)
    );

    assign seg       = (idx_q == 2'd3 && neg_disp_q) ? SEG_MINUS : dec_seg;
    assign an        = ~(4'd1 << idx_q);
    assign out_value = out_value_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sap1_out_display.sv
// Directed bench for sap1_out_display with a short scan divider.
module tb_sap1_out_display;

    logic       clk = 1'b0;
    logic       CLR;
    logic       CLK;
    logic       nLO;
    logic [7:0] DBUS;
    logic       signed_mode;
    logic [7:0] out_value;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] an;

    int checks    = 0;
    int failures  = 0;
    int busy_cnt  = 0;
    logic watch   = 1'b0;
    logic saw_bad = 1'b0;

    sap1_out_display #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .CLR         (CLR),
        .CLK         (CLK),
        .nLO         (nLO),
        .DBUS        (DBUS),
        .signed_mode (signed_mode),
        .out_value   (out_value),
        .busy        (busy),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (watch && an == 4'b1011 && seg !== 8'hFF) saw_bad = 1'b1;
    endtask

    task automatic load(input logic [7:0] v);
        DBUS = v;
        nLO  = 1'b0;
        CLK  = 1'b1;
        tick();
        CLK  = 1'b0;
        nLO  = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) chk(tag, busy, 0);
    endtask

    task automatic check_digit(input int idx, input logic [7:0] exp, input string tag);
        logic [3:0] want;
        int g = 0;
        want = ~(4'd1 << idx);
        while (an !== want && g < 20) begin
            tick();
            g++;
        end
        chk({tag, "_an"}, an, want);
        chk(tag, seg, exp);
    endtask

    initial begin
        CLR = 1'b1; CLK = 1'b0; nLO = 1'b1; DBUS = 8'd0; signed_mode = 1'b0;
        tick();
        tick();
        chk("rst_out", out_value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 8'hC0);
        CLR = 1'b0;
        chk("rel_an0", an, 4'b1110);
        chk("rel_seg0", seg, 8'hC0);
        repeat (4) tick();
        chk("scan_an1", an, 4'b1101);
        chk("scan_seg1", seg, 8'hFF);
        repeat (4) tick();
        chk("scan_an2", an, 4'b1011);
        chk("scan_seg2", seg, 8'hFF);
        repeat (4) tick();
        chk("scan_an3", an, 4'b0111);
        chk("scan_seg3", seg, 8'hFF);
        repeat (4) tick();
        chk("scan_wrap_an", an, 4'b1110);

        // 173 unsigned
        busy_cnt = 0;
        load(8'd173);
        chk("ld173_out", out_value, 173);
        chk("ld173_busy", busy, 1);
        wait_idle("ld173_timeout");
        chk("ld173_busylen", busy_cnt, 17);
        check_digit(2, 8'hF9, "d173_h");
        check_digit(1, 8'hF8, "d173_t");
        check_digit(0, 8'hB0, "d173_u");
        check_digit(3, 8'hFF, "d173_s");

        // nLO high: no load
        busy_cnt = 0;
        DBUS = 8'd55; nLO = 1'b1; CLK = 1'b1;
        tick();
        CLK = 1'b0;
        tick();
        chk("noload_out", out_value, 173);
        chk("noload_busy", busy_cnt, 0);
        check_digit(0, 8'hB0, "noload_u");

        // CLK held high for 10 cycles: exactly one load
        busy_cnt = 0;
        DBUS = 8'd55; nLO = 1'b0; CLK = 1'b1;
        tick();
        chk("hold_out", out_value, 55);
        DBUS = 8'd77;
        repeat (9) tick();
        CLK = 1'b0; nLO = 1'b1;
        wait_idle("hold_timeout");
        chk("hold_busylen", busy_cnt, 17);
        chk("hold_out2", out_value, 55);
        check_digit(2, 8'hFF, "d55_h");
        check_digit(1, 8'h92, "d55_t");
        check_digit(0, 8'h92, "d55_u");

        // Signed -128
        signed_mode = 1'b1;
        load(8'h80);
        wait_idle("m128_timeout");
        chk("m128_out", out_value, 8'h80);
        check_digit(3, 8'hBF, "m128_s");
        check_digit(2, 8'hF9, "m128_h");
        check_digit(1, 8'hA4, "m128_t");
        check_digit(0, 8'h80, "m128_u");

        // Signed -1
        load(8'hFF);
        wait_idle("m1_timeout");
        check_digit(3, 8'hBF, "m1_s");
        check_digit(2, 8'hFF, "m1_h");
        check_digit(1, 8'hFF, "m1_t");
        check_digit(0, 8'hF9, "m1_u");

        // Unsigned 255
        signed_mode = 1'b0;
        load(8'hFF);
        wait_idle("u255_timeout");
        check_digit(3, 8'hFF, "u255_s");
        check_digit(2, 8'hA4, "u255_h");
        check_digit(1, 8'h92, "u255_t");
        check_digit(0, 8'h92, "u255_u");

        // Abort: 200 interrupted by 9 at busy cycle 5
        load(8'd0);
        wait_idle("zero_timeout");
        check_digit(0, 8'hC0, "zero_u");
        busy_cnt = 0;
        saw_bad  = 1'b0;
        watch    = 1'b1;
        load(8'd200);
        repeat (3) tick();
        load(8'd9);
        wait_idle("abort_timeout");
        chk("abort_busylen", busy_cnt, 21);
        chk("abort_out", out_value, 9);
        check_digit(0, 8'h90, "abort_u");
        check_digit(1, 8'hFF, "abort_t");
        check_digit(2, 8'hFF, "abort_h");
        check_digit(3, 8'hFF, "abort_s");
        watch = 1'b0;
        chk("abort_no200", saw_bad, 0);

        // CLR mid-conversion
        busy_cnt = 0;
        load(8'd99);
        repeat (7) tick();
        chk("clr_pre_busy", busy_cnt, 8);
        CLR = 1'b1;
        #1;
        chk("clr_busy", busy, 0);
        chk("clr_an", an, 4'b1110);
        chk("clr_seg", seg, 8'hC0);
        chk("clr_out", out_value, 0);
        tick();
        CLR = 1'b0;
        busy_cnt = 0;
        repeat (30) tick();
        chk("clr_nocommit_busy", busy_cnt, 0);
        check_digit(1, 8'hFF, "clr_t");
        check_digit(0, 8'hC0, "clr_u");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sap1_out_display.md
Name: sap1_out_display

Overview:
Output end of the SAP-1 bus interface. Captures DBUS into the output register when the control unit asserts nLO on a rising edge of the SAP-1 CLK. Converts the captured value to decimal with a sequential double-dabble engine and drives a 4-digit multiplexed 7-segment display. It is the counterpart to the front-panel input/clock block and runs on the same system clock clk.

Parameters:
SCAN_DIV, 50_000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); must be ≥2.

Ports:
clk  input  1  system clock (50 MHz), the only clock
CLR  input  1  asynchronous active-high reset
CLK  input  1  SAP-1 machine clock level, sampled in clk domain (generated from clk, no synchroniser)
nLO  input  1  active-low output-register load from control unit
DBUS  input  8  SAP-1 data bus
signed_mode  input  1  1 = treat value as two's complement
out_value  output  8  current output register contents
busy  output  1  conversion in progress
seg  output  8  segments active-low, {dp,g,f,e,d,c,b,a}
an  output  4  digit enables active-low, one-hot-zero, an[0] = units

Behaviour:
- Reset (CLR high, async): out_value=0, busy=0, FSM IDLE, committed BCD=000, negative flag=0, scan counter=0, digit index=0. Outputs are an=4'b1110 and seg=8'hC0 ('0').
- Edge detect: register clk_prev<=CLK each clk. load_evt = CLK & ~clk_prev & ~nLO. out_value<=DBUS on the clk edge following the cycle where load_evt is true (1-cycle latency). nLO high at the edge means no load. Only one load per SAP-1 CLK high period.
- Magnitude: if signed_mode & DBUS[7], mag = -DBUS (8-bit unsigned; 0x80 -> 128) and neg=1. Otherwise mag = DBUS and neg=0. Both are latched with the load.
- FSM states:
  - IDLE: on load_evt go to ADJUST; set busy=1, shift reg {bcd[11:0],bin[7:0]} = {0,mag}, iter=0.
  - ADJUST: each BCD nibble ≥5 gets +3.
  - SHIFT: whole register shifts left by 1; iter++. If iter==7 before the increment, go to COMMIT, else back to ADJUST.
  - COMMIT: copy bcd and neg to the display registers; busy=0; go to IDLE.
- Latency: load_evt to committed display is 17 clk (8×ADJUST + 8×SHIFT + COMMIT); busy is high for exactly 17 cycles.
- load_evt in any non-IDLE state aborts the current conversion and restarts from ADJUST with the new magnitude. The partial result is never committed. busy stays high.
- The display always shows the last committed value and never shows intermediate states.
- Scan: counter counts 0..SCAN_DIV-1 then wraps. On wrap, the digit index advances 0→1→2→3→0. an = ~(1<<index).
- Digit content:
  - idx0: units.
  - idx1: tens; blank if hundreds==0 and tens==0.
  - idx2: hundreds; blank if 0.
  - idx3: minus (8'hBF) if neg, else blank (8'hFF).
  - dp is always off.
- Glyphs, digits 0-9: C0,F9,A4,B0,99,92,82,F8,80,90. Nibbles above 9 are unreachable; they decode as blank.
- CLR mid-conversion: immediate return to the reset values above; the in-flight load is discarded.

Decomposition:
- Package sap1_out_pkg holds:
  - FSM state enum (IDLE, ADJUST, SHIFT, COMMIT).
  - Glyph constants SEG_BLANK=8'hFF, SEG_MINUS=8'hBF.
  - The 10-entry digit glyph table.
- One sub-module, sevenseg_decode: combinational 4-bit nibble plus blank flag -> 8-bit active-low segments.
- Scan, FSM and capture stay in sap1_out_display.

Test Plan:
- Assert CLR, then release -> out_value=0, busy=0, an=1110, seg=C0. Stepping with SCAN_DIV=4: an shows 1101/1011/0111 with seg=FF.
- DBUS=8'd173, nLO=0, pulse CLK -> out_value=173 one clk after the edge, busy high 17 clk. Digits are idx2=F9, idx1=F8, idx0=B0, idx3=FF.
- DBUS=8'd55, nLO=1, pulse CLK -> out_value, busy and display unchanged. Hold CLK high 10 clk with nLO=0 -> exactly one load.
- signed_mode=1:
  - DBUS=8'h80 -> display "-128" (BF,F9,A4,80).
  - DBUS=8'hFF -> idx3=BF, idx2=FF, idx1=FF, idx0=F9.
  - signed_mode=0, DBUS=8'hFF -> "255".
- Load 200, then load 9 at busy cycle 5 -> busy is continuous and ends 17 clk after the second load. Final display is idx0=90 with tens and hundreds blank. No 200 glyphs ever appear on the display.
- Load 99, assert CLR at busy cycle 8 -> immediate reset state (seg=C0 on an=1110, busy=0). No commit follows after CLR releases.
